mem_read_responder: RTL and testbench

Memory-side responder for the core's multi-cycle pipeline. It owns a word-addressed instruction/data RAM and answers the level-held read requests issued during the fetch-request and memory-read pipeline states, returning data with a one-cycle `memoryReadValid` pulse after a fixed, parameterised latency. It also accepts single-cycle byte-masked writes from the writeback path.

---
 rtl/mem_read_responder.sv | 123 ++++++++++++
 tb/tb_mem_read_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_responder.sv
// Word-addressed RAM answering level-held reads after READ_LATENCY edges, plus byte-masked writes.
// Optional misalignment checking is enabled by defining MEM_RESP_MISALIGN_CHECK_EN.
module mem_read_responder #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  readRequest,
  input  logic [ADDR_WIDTH+1:0] readAddress,
  input  logic                  writeEnable,
  input  logic [ADDR_WIDTH+1:0] writeAddress,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic [3:0]            writeMask,
  output logic                  memoryReadValid,
  output logic [DATA_WIDTH-1:0] readData,
  output logic                  writeAck,
  output logic                  readError,
  output logic                  busy
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0]  LOAD  = 4'(READ_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

  state_t                state, stateNext;
  logic [3:0]            count, countNext;
  logic [ADDR_WIDTH-1:0] addrReg;
  logic [ADDR_WIDTH-1:0] captureWord;
  logic                  misReg, misNow, captureMis;
  logic                  accept, capture, doWrite, writeDrop;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

`ifdef MEM_RESP_MISALIGN_CHECK_EN
  assign misNow    = (readAddress[1:0] != 2'b00);
  assign writeDrop = (writeAddress[1:0] != 2'b00);
`else
  logic unusedAlign;
  assign unusedAlign = ^{readAddress[1:0], writeAddress[1:0]};
  assign misNow      = 1'b0;
  assign writeDrop   = 1'b0;
`endif

  // With READ_LATENCY=1 the capture happens on the acceptance edge, so use the live address.
  assign captureWord = (state == IDLE) ? readAddress[ADDR_WIDTH+1:2] : addrReg;
  assign captureMis  = (state == IDLE) ? misNow : misReg;

  always_comb begin
    stateNext = state;
    countNext = count;
    accept    = 1'b0;
    capture   = 1'b0;
    doWrite   = 1'b0;
    case (state)
      IDLE: begin
        if (writeEnable) begin
          doWrite = 1'b1;
        end else if (readRequest) begin
          accept = 1'b1;
          if (READ_LATENCY == 1) begin
            capture   = 1'b1;
            countNext = '0;
            stateNext = RESPOND;
          end else begin
            countNext = LOAD;
            stateNext = WAIT;
          end
        end
      end
      WAIT: begin
        countNext = count - 4'd1;
        if (count <= 4'd1) begin
          capture   = 1'b1;
          countNext = '0;
          stateNext = RESPOND;
        end
      end
      RESPOND: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      count           <= '0;
      addrReg         <= '0;
      misReg          <= 1'b0;
      memoryReadValid <= 1'b0;
      readData        <= '0;
      writeAck        <= 1'b0;
      readError       <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state           <= stateNext;
      count           <= countNext;
      memoryReadValid <= (stateNext == RESPOND);
      busy            <= (stateNext != IDLE);
      writeAck        <= doWrite;
      readError       <= capture && captureMis;
      if (accept) begin
        addrReg <= readAddress[ADDR_WIDTH+1:2];
        misReg  <= misNow;
      end
      if (capture) begin
        readData <= captureMis ? '0 : mem[captureWord];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (doWrite && !writeDrop) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (writeMask[b]) begin
          mem[writeAddress[ADDR_WIDTH+1:2]][8*b +: 8] <= writeData[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_read_responder.sv
// Randomized bench for mem_read_responder with a timeline-based reference model and directed literal checks.
module tb_mem_read_responder;
  localparam int unsigned AW = 10;
  localparam int          RL = 2;
`ifdef MEM_RESP_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          readRequest = 1'b0;
  logic [AW+1:0] readAddress = '0;
  logic          writeEnable = 1'b0;
  logic [AW+1:0] writeAddress = '0;
  logic [31:0]   writeData = '0;
  logic [3:0]    writeMask = '0;
  logic          memoryReadValid, writeAck, readError, busy;
  logic [31:0]   readData;

  int nVec = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  mem_read_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .READ_LATENCY(RL)) dut (
    .clk(clk), .reset(reset),
    .readRequest(readRequest), .readAddress(readAddress),
    .writeEnable(writeEnable), .writeAddress(writeAddress),
    .writeData(writeData), .writeMask(writeMask),
    .memoryReadValid(memoryReadValid), .readData(readData),
    .writeAck(writeAck), .readError(readError), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: shadow memory plus the cycle numbers at which each response is due.
  logic [31:0] sh [1 << AW];
  int          c = 0;
  int          busyFrom = 0, idleFrom = 0, respAt = -1, ackAt = -1;
  logic [31:0] pendData = '0, lastData = '0;
  bit          pendErr = 1'b0;

  initial begin
    bit expValid;
    bit mis;
    forever begin
      @(negedge clk);
      c++;
      if (!reset) begin
        check("rst_valid", memoryReadValid, 0);
        check("rst_ack", writeAck, 0);
        check("rst_err", readError, 0);
        check("rst_busy", busy, 0);
        check("rst_data", readData, 0);
        respAt = -1; ackAt = -1; idleFrom = 0; busyFrom = 0; lastData = '0;
      end else begin
        expValid = (c == respAt);
        if (expValid) lastData = pendData;
        check("m_valid", memoryReadValid, expValid);
        check("m_data", readData, lastData);
        check("m_ack", writeAck, (c == ackAt));
        check("m_err", readError, expValid && pendErr);
        check("m_busy", busy, (c >= busyFrom && c < idleFrom));
        if (c >= idleFrom) begin
          if (writeEnable) begin
            ackAt = c + 1;
            if (!(MIS_EN && writeAddress[1:0] != 2'b00)) begin
              for (int b = 0; b < 4; b++)
                if (writeMask[b]) sh[writeAddress[AW+1:2]][8*b +: 8] = writeData[8*b +: 8];
            end
          end else if (readRequest) begin
            mis      = MIS_EN && (readAddress[1:0] != 2'b00);
            busyFrom = c + 1;
            respAt   = c + RL;
            idleFrom = c + RL + 1;
            pendData = mis ? 32'h0 : sh[readAddress[AW+1:2]];
            pendErr  = mis;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doWrite(input logic [AW+1:0] a, input logic [31:0] d, input logic [3:0] m);
    writeEnable = 1'b1; writeAddress = a; writeData = d; writeMask = m;
    tick();
    writeEnable = 1'b0;
    check("wr_ack", writeAck, 1);
  endtask

  task automatic waitValid(output int k, output logic [31:0] d, output logic e);
    bit found = 1'b0;
    k = 0; d = '0; e = 1'b0;
    for (int i = 1; i <= 40 && !found; i++) begin
      tick();
      if (memoryReadValid) begin
        found = 1'b1; k = i; d = readData; e = readError;
      end
    end
    if (!found) begin
      nVec++; nFail++;
      $display("FAIL valid_timeout: got no memoryReadValid required one within 40 cycles");
    end
  endtask

  task automatic doRead(input logic [AW+1:0] a, output logic [31:0] d, output logic e, output int k);
    readRequest = 1'b1; readAddress = a;
    waitValid(k, d, e);
    readRequest = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] d, d2;
    logic        e;
    int          k, k2;

    repeat (3) tick();
    reset = 1'b1;
    tick();

    doWrite(12'h010, 32'hDEADBEEF, 4'b1111);
    doRead(12'h010, d, e, k);
    check("lat_basic", k, 2);
    check("rd_deadbeef", d, 32'hDEADBEEF);

    doWrite(12'h010, 32'h000000AA, 4'b0001);
    doRead(12'h010, d, e, k);
    check("rd_masked", d, 32'hDEADBEAA);

    doWrite(12'h014, 32'hCAFEF00D, 4'b1111);
    readRequest = 1'b1; readAddress = 12'h010;
    waitValid(k, d, e);
    readAddress = 12'h014;
    waitValid(k2, d2, e);
    readRequest = 1'b0;
    tick();
    check("hold_d1", d, 32'hDEADBEAA);
    check("hold_d2", d2, 32'hCAFEF00D);
    check("hold_spacing", k2, 3);

    writeEnable = 1'b1; writeAddress = 12'h020; writeData = 32'h12345678; writeMask = 4'hF;
    readRequest = 1'b1; readAddress = 12'h020;
    tick();
    writeEnable = 1'b0;
    check("sim_ack", writeAck, 1);
    check("sim_novalid", memoryReadValid, 0);
    waitValid(k, d, e);
    readRequest = 1'b0;
    tick();
    check("sim_lat", k, 2);
    check("sim_data", d, 32'h12345678);

    readRequest = 1'b1; readAddress = 12'h014;
    tick();
    check("wait_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("async_busy", busy, 0);
    check("async_valid", memoryReadValid, 0);
    check("async_data", readData, 0);
    readRequest = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_novalid", memoryReadValid, 0);
    end
    doRead(12'h010, d, e, k);
    check("post_rst_data", d, 32'hDEADBEAA);

    doRead(12'h012, d, e, k);
    check("mis_data", d, MIS_EN ? 32'h0 : 32'hDEADBEAA);
    check("mis_err", e, MIS_EN);

    for (int w = 0; w < 16; w++) doWrite(12'(w * 4 + 64), $urandom, 4'hF);

    for (int i = 0; i < 500; i++) begin
      if (readRequest && memoryReadValid) begin
        if ($urandom_range(0, 1) == 0) readRequest = 1'b0;
        else readAddress = 12'($urandom_range(0, 15) * 4 + 64 + $urandom_range(0, 3));
      end else if (!readRequest && $urandom_range(0, 3) == 0) begin
        readRequest = 1'b1;
        readAddress = 12'($urandom_range(0, 15) * 4 + 64 + $urandom_range(0, 3));
      end
      writeEnable  = ($urandom_range(0, 9) < 3);
      writeAddress = 12'($urandom_range(0, 15) * 4 + 64 + $urandom_range(0, 3));
      writeData    = $urandom;
      writeMask    = 4'($urandom_range(0, 15));
      tick();
    end
    readRequest = 1'b0;
    writeEnable = 1'b0;
    repeat (6) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end
endmodule
